seg_bcd_formatter: RTL and testbench

Converts a binary calculator result into eight active-low seven-segment patterns and holds them stable for the downstream eight-digit display multiplexer. A sequential double-dabble engine performs the binary-to-BCD conversion over a fixed number of cycles. The segment encoder then applies sign placement, overflow indication and (optionally) leading-zero blanking. Outputs change only on completion of a conversion, so the multiplexer never scans a partially updated value.

---
 rtl/seg_bcd_formatter_if.sv | 26 ++
 rtl/seg_bcd_formatter.sv | 132 +++++++++++++
 tb/tb_seg_bcd_formatter.sv | 295 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/seg_bcd_formatter_if.sv
// seg_bcd_formatter_if: request/result bundle between a calculator core and the segment formatter
interface seg_bcd_formatter_if;
    logic        start;
    logic [26:0] value;
    logic        neg;
    logic        busy;
    logic        done;
    logic [7:0]  LED0;
    logic [7:0]  LED1;
    logic [7:0]  LED2;
    logic [7:0]  LED3;
    logic [7:0]  LED4;
    logic [7:0]  LED5;
    logic [7:0]  LED6;
    logic [7:0]  LED7;

    modport master (
        output start, value, neg,
        input  busy, done, LED0, LED1, LED2, LED3, LED4, LED5, LED6, LED7
    );

    modport slave (
        input  start, value, neg,
        output busy, done, LED0, LED1, LED2, LED3, LED4, LED5, LED6, LED7
    );
endinterface

// File: rtl/seg_bcd_formatter.sv
// seg_bcd_formatter: sequential double-dabble to eight held active-low 7-seg digits; SEG_LZB_EN enables leading-zero blanking
module seg_bcd_formatter #(
    parameter logic [7:0] BLANK_PAT = 8'hFF,
    parameter logic [7:0] DASH_PAT  = 8'hBF
) (
    input logic           clk,
    input logic           rst_n,
    seg_bcd_formatter_if.slave bus
);
`ifdef SEG_LZB_EN
    localparam bit LZB = 1'b1;
`else
    localparam bit LZB = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, SHIFT, FORMAT} state_t;

    state_t      state;
    state_t      state_next;
    logic [26:0] bin;
    logic [26:0] val_q;
    logic        neg_q;
    logic [31:0] bcd;
    logic [31:0] bcd_adj;
    logic [4:0]  cnt;
    logic        ovf;
    logic        neg_eff;
    logic [8:0]  lz;
    logic        run;
    logic        done_q;
    logic [7:0]  pat   [8];
    logic [7:0]  led_q [8];

    function automatic logic [7:0] seg_code(input logic [3:0] d);
        case (d)
            4'd0:    seg_code = 8'hC0;
            4'd1:    seg_code = 8'hF9;
            4'd2:    seg_code = 8'hA4;
            4'd3:    seg_code = 8'hB0;
            4'd4:    seg_code = 8'h99;
            4'd5:    seg_code = 8'h92;
            4'd6:    seg_code = 8'h82;
            4'd7:    seg_code = 8'hF8;
            4'd8:    seg_code = 8'h80;
            4'd9:    seg_code = 8'h90;
            default: seg_code = BLANK_PAT;
        endcase
    endfunction

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_next;
    end

    // FSM next state: 27 shift cycles, then one format cycle; start only heard in IDLE
    always_comb begin
        state_next = IDLE;
        state_next = state == IDLE  ? (bus.start ? SHIFT : IDLE) :
                     state == SHIFT ? (cnt == 5'd26 ? FORMAT : SHIFT) : IDLE;
    end

    // Double-dabble correction: bump every BCD nibble >= 5 before the shift
    always_comb begin
        bcd_adj = bcd;
        for (int i = 0; i < 8; i++)
            bcd_adj[4*i +: 4] = bcd[4*i +: 4] >= 4'd5 ? bcd[4*i +: 4] + 4'd3 : bcd[4*i +: 4];
    end

    // Operand capture and shift engine
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bin   <= '0;
            val_q <= '0;
            neg_q <= 1'b0;
            bcd   <= '0;
            cnt   <= '0;
        end else if (state == IDLE && bus.start) begin
            bin   <= bus.value;
            val_q <= bus.value;
            neg_q <= bus.neg;
            bcd   <= '0;
            cnt   <= '0;
        end else if (state == SHIFT) begin
            {bcd, bin} <= {bcd_adj, bin} << 1;
            cnt        <= cnt + 5'd1;
        end
    end

    assign ovf     = val_q > 27'd99_999_999 || (neg_q && val_q > 27'd9_999_999);
    assign neg_eff = neg_q && val_q != '0;

    // Segment encoding: lz[i] marks digit i as a leading zero (the ones digit never is)
    always_comb begin
        run = 1'b1;
        lz  = '0;
        for (int i = 0; i < 7; i++) begin
            run   = run && bcd[28-4*i +: 4] == 4'd0;
            lz[i] = run;
        end
        for (int i = 0; i < 8; i++)
            pat[i] = (ovf || (neg_eff && (LZB ? lz[i] && !lz[i+1] : i == 0))) ? DASH_PAT :
                     (LZB && lz[i]) ? BLANK_PAT : seg_code(bcd[28-4*i +: 4]);
    end

    // Output hold registers: only the FORMAT edge updates the digits
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done_q <= 1'b0;
            for (int i = 0; i < 8; i++)
                led_q[i] <= BLANK_PAT;
        end else begin
            done_q <= state == FORMAT;
            if (state == FORMAT)
                for (int i = 0; i < 8; i++)
                    led_q[i] <= pat[i];
        end
    end

    assign bus.busy = state != IDLE;
    assign bus.done = done_q;
    assign bus.LED0 = led_q[0];
    assign bus.LED1 = led_q[1];
    assign bus.LED2 = led_q[2];
    assign bus.LED3 = led_q[3];
    assign bus.LED4 = led_q[4];
    assign bus.LED5 = led_q[5];
    assign bus.LED6 = led_q[6];
    assign bus.LED7 = led_q[7];
endmodule

// File: tb/tb_seg_bcd_formatter.sv
// tb_seg_bcd_formatter: randomized and directed checks of seg_bcd_formatter against an arithmetic display model
module tb_seg_bcd_formatter;
    localparam logic [7:0] BLANK = 8'hFF;
    localparam logic [7:0] DASH  = 8'hBF;
    localparam logic [7:0] CODES [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                                          8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    logic [7:0] led [8];

    seg_bcd_formatter_if bus ();

    seg_bcd_formatter dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    assign led[0] = bus.LED0;
    assign led[1] = bus.LED1;
    assign led[2] = bus.LED2;
    assign led[3] = bus.LED3;
    assign led[4] = bus.LED4;
    assign led[5] = bus.LED5;
    assign led[6] = bus.LED6;
    assign led[7] = bus.LED7;

    // Expected pattern of digit i (0 = leftmost) for magnitude v and sign n
    function automatic logic [7:0] exp_pat(input int unsigned v, input bit n, input int i);
        int unsigned p;
        int          width;
        bit          neg_eff;
        p = 1;
        for (int k = 0; k < 7 - i; k++) p = p * 10;
        if (v > 99999999 || (n && v > 9999999)) return DASH;
        neg_eff = n && v != 0;
        width = 1;
        for (int unsigned t = v; t >= 10; t = t / 10) width++;
`ifdef SEG_LZB_EN
        if (i >= 8 - width) return CODES[(v / p) % 10];
        return (neg_eff && i == 7 - width) ? DASH : BLANK;
`else
        return (neg_eff && i == 0) ? DASH : CODES[(v / p) % 10];
`endif
    endfunction

    // Called at a falling edge; returns at the falling edge where done is seen (or after the bound)
    task automatic run(input int unsigned v, input bit n, output int lat);
        bus.start = 1'b1;
        bus.value = v[26:0];
        bus.neg   = n;
        @(negedge clk);
        bus.start = 1'b0;
        bus.value = 27'($urandom);
        bus.neg   = 1'($urandom);
        lat = 0;
        while (bus.done !== 1'b1 && lat < 60) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic test_reset;
        bus.start = 1'b0;
        bus.value = '0;
        bus.neg   = 1'b0;
        rst_n     = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl busy=%b done=%b want 0 0", bus.busy, bus.done);
        end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (led[i] !== BLANK) begin
                errors++;
                $display("FAIL reset_led%0d got %h want %h", i, led[i], BLANK);
            end
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_sign;
        int lat;
        for (int s = 0; s < 2; s++) begin
            run(1234, s[0], lat);
            checks++;
            if (lat !== 28) begin
                errors++;
                $display("FAIL sign_latency neg=%0d got %0d want 28", s, lat);
            end
            checks++;
            if (led[7] !== 8'h99 || led[4] !== 8'hF9) begin
                errors++;
                $display("FAIL sign_digits neg=%0d led4=%h led7=%h want f9 99", s, led[4], led[7]);
            end
            for (int i = 0; i < 8; i++) begin
                checks++;
                if (led[i] !== exp_pat(1234, s[0], i)) begin
                    errors++;
                    $display("FAIL sign_led%0d neg=%0d got %h want %h", i, s, led[i], exp_pat(1234, s[0], i));
                end
            end
        end
    endtask

    task automatic test_zero;
        int lat;
        logic [7:0] pos [8];
        for (int s = 0; s < 2; s++) begin
            run(0, s[0], lat);
            checks++;
            if (led[7] !== 8'hC0) begin
                errors++;
                $display("FAIL zero_led7 neg=%0d got %h want c0", s, led[7]);
            end
            for (int i = 0; i < 8; i++) begin
                if (s == 0) pos[i] = led[i];
                checks++;
                if (led[i] !== exp_pat(0, 1'b0, i) || led[i] !== pos[i]) begin
                    errors++;
                    $display("FAIL zero_led%0d neg=%0d got %h want %h", i, s, led[i], exp_pat(0, 1'b0, i));
                end
            end
        end
    endtask

    task automatic test_overflow;
        int lat;
        int unsigned vals [5] = '{100000000, 99999999, 10000000, 9999999, 134217727};
        bit          negs [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        for (int t = 0; t < 5; t++) begin
            run(vals[t], negs[t], lat);
            checks++;
            if (lat !== 28) begin
                errors++;
                $display("FAIL ovf_latency v=%0d got %0d want 28", vals[t], lat);
            end
            for (int i = 0; i < 8; i++) begin
                checks++;
                if (led[i] !== exp_pat(vals[t], negs[t], i)) begin
                    errors++;
                    $display("FAIL ovf_led%0d v=%0d neg=%0d got %h want %h", i, vals[t], negs[t], led[i], exp_pat(vals[t], negs[t], i));
                end
            end
            if (t == 1) begin
                checks++;
                if (led[0] !== 8'h90 || led[7] !== 8'h90) begin
                    errors++;
                    $display("FAIL max_nines led0=%h led7=%h want 90 90", led[0], led[7]);
                end
            end
        end
    endtask

    task automatic test_start_while_busy;
        int lat;
        int dones;
        int first;
        bus.start = 1'b1;
        bus.value = 27'd5;
        bus.neg   = 1'b0;
        @(negedge clk);
        bus.start = 1'b0;
        checks++;
        if (bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL busy_after_start got %b want 1", bus.busy);
        end
        dones = 0;
        first = -1;
        for (lat = 0; lat <= 40 && first < 0; lat++) begin
            if (lat > 0) @(negedge clk);
            bus.start = lat == 9;
            bus.value = lat == 9 ? 27'd7 : 27'($urandom);
            bus.neg   = 1'($urandom);
            if (bus.done === 1'b1) begin
                dones++;
                first = lat;
            end
        end
        bus.start = 1'b0;
        checks++;
        if (dones !== 1 || first !== 28) begin
            errors++;
            $display("FAIL busy_done count=%0d at=%0d want 1 at 28", dones, first);
        end
        checks++;
        if (led[7] !== 8'h92) begin
            errors++;
            $display("FAIL busy_led7 got %h want 92", led[7]);
        end
        run(3, 1'b0, lat);
        checks++;
        if (lat !== 28 || led[7] !== 8'hB0) begin
            errors++;
            $display("FAIL after_done_start lat=%0d led7=%h want 28 b0", lat, led[7]);
        end
    endtask

    task automatic test_reset_mid;
        int lat;
        int dones;
        bus.start = 1'b1;
        bus.value = 27'd87654321;
        bus.neg   = 1'b0;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (14) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            errors++;
            $display("FAIL midreset_ctrl busy=%b done=%b want 0 0", bus.busy, bus.done);
        end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (led[i] !== BLANK) begin
                errors++;
                $display("FAIL midreset_led%0d got %h want %h", i, led[i], BLANK);
            end
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        dones = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.done === 1'b1) dones++;
        end
        checks++;
        if (dones !== 0) begin
            errors++;
            $display("FAIL midreset_done got %0d pulses want 0", dones);
        end
        run(4321, 1'b1, lat);
        checks++;
        if (lat !== 28) begin
            errors++;
            $display("FAIL midreset_next_latency got %0d want 28", lat);
        end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (led[i] !== exp_pat(4321, 1'b1, i)) begin
                errors++;
                $display("FAIL midreset_next_led%0d got %h want %h", i, led[i], exp_pat(4321, 1'b1, i));
            end
        end
    endtask

    task automatic test_back_to_back;
        int lat;
        int unsigned v;
        bit n;
        int unsigned lim [9] = '{9, 99, 999, 9999, 99999, 999999, 9999999, 99999999, 134217727};
        for (int t = 0; t < 40; t++) begin
            v = $urandom_range(lim[$urandom_range(0, 8)], 0);
            n = 1'($urandom);
            run(v, n, lat);
            checks++;
            if (lat !== 28) begin
                errors++;
                $display("FAIL b2b_latency v=%0d got %0d want 28", v, lat);
            end
            for (int i = 0; i < 8; i++) begin
                checks++;
                if (led[i] !== exp_pat(v, n, i)) begin
                    errors++;
                    $display("FAIL b2b_led%0d v=%0d neg=%0d got %h want %h", i, v, n, led[i], exp_pat(v, n, i));
                end
            end
        end
        @(negedge clk);
        checks++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL b2b_idle done=%b busy=%b want 0 0", bus.done, bus.busy);
        end
    endtask

    initial begin
        test_reset;
        test_sign;
        test_zero;
        test_overflow;
        test_start_while_busy;
        test_reset_mid;
        test_back_to_back;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
